// File: rtl/enc_frame_scheduler_pkg.sv
// Shared types and defaults for the framed encoder scheduler.
// Holds the FSM encoding and the header byte layout.
package enc_frame_scheduler_pkg;

   localparam int         LEN_W_DEF    = 4;
   localparam logic [3:0] SYNC_NIB_DEF = 4'hA;
   localparam int         HDR_PAD_W    = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LEN,
      S_PAY,
      S_CSUM
   } state_t;

   // Header: sync nibble, zero pad, source id in bit 0.
   function automatic logic [7:0] hdr_byte(
      input logic [3:0] sync,
      input logic       src
   );
      return {sync, {HDR_PAD_W{1'b0}}, src};
   endfunction

endpackage

// File: rtl/enc_frame_scheduler_encoder.sv
// Nibble-increment encoder: each nibble +1 mod 16.
// Purely combinational; no carry between nibbles.
module enc_frame_scheduler_encoder (
   input  logic [7:0] raw,
   output logic [7:0] enc
);

   assign enc = {raw[7:4] + 4'd1, raw[3:0] + 4'd1};

endmodule

// File: rtl/enc_frame_scheduler.sv
// Round-robin framer sharing one encoder between two byte sources.
// Emits header, length, encoded payload and XOR checksum on one TX stream.
module enc_frame_scheduler
   import enc_frame_scheduler_pkg::*;
#(
   parameter int         LEN_W    = LEN_W_DEF,
   parameter logic [3:0] SYNC_NIB = SYNC_NIB_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       src_req,
   input  logic [LEN_W-1:0] src_len0,
   input  logic [LEN_W-1:0] src_len1,
   input  logic [7:0]       src_data0,
   input  logic [7:0]       src_data1,
   input  logic [1:0]       src_valid,
   output logic [1:0]       src_ready,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             tx_last,
   output logic             frame_done
);

   state_t           state, state_nx;
   logic [1:0]       gnt_nx;
   logic             last_gnt, last_gnt_nx;
   logic [LEN_W-1:0] len_q, len_nx;
   logic [LEN_W-1:0] cnt, cnt_nx;
   logic [7:0]       csum, csum_nx;
   logic [7:0]       data_nx;
   logic             valid_nx, last_nx;

   logic       load_en;
   logic       pick;
   logic       sel_valid;
   logic [7:0] sel_data;
   logic [7:0] enc_byte;
   logic [7:0] hdr;
   logic [7:0] len_byte;

   assign load_en   = !tx_valid || tx_ready;
   // Both requesting: the source that did not win last time goes next.
   assign pick      = (&src_req) ? ~last_gnt : src_req[1];
   assign sel_valid = gnt[1] ? src_valid[1] : src_valid[0];
   assign sel_data  = gnt[1] ? src_data1 : src_data0;
   assign hdr       = hdr_byte(SYNC_NIB, gnt[1]);
   assign len_byte  = 8'(len_q);

   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_CSUM) && tx_valid
                       && tx_last && tx_ready;

   enc_frame_scheduler_encoder u_enc (
      .raw (sel_data),
      .enc (enc_byte)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         gnt      <= '0;
         last_gnt <= 1'b1;
         len_q    <= '0;
         cnt      <= '0;
         csum     <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
      end else begin
         state    <= state_nx;
         gnt      <= gnt_nx;
         last_gnt <= last_gnt_nx;
         len_q    <= len_nx;
         cnt      <= cnt_nx;
         csum     <= csum_nx;
         tx_data  <= data_nx;
         tx_valid <= valid_nx;
         tx_last  <= last_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      gnt_nx      = gnt;
      last_gnt_nx = last_gnt;
      len_nx      = len_q;
      cnt_nx      = cnt;
      csum_nx     = csum;
      data_nx     = tx_data;
      valid_nx    = tx_valid;
      last_nx     = tx_last;
      src_ready   = 2'b00;

      // A consumed byte drops valid unless a new one is loaded below.
      if (load_en) begin
         valid_nx = 1'b0;
         last_nx  = 1'b0;
      end

      unique case (state)
         S_IDLE: begin
            if (|src_req) begin
               gnt_nx      = pick ? 2'b10 : 2'b01;
               last_gnt_nx = pick;
               len_nx      = pick ? src_len1 : src_len0;
               cnt_nx      = '0;
               state_nx    = S_HDR;
            end
         end
         S_HDR: begin
            if (load_en) begin
               data_nx  = hdr;
               valid_nx = 1'b1;
               csum_nx  = hdr;
               state_nx = S_LEN;
            end
         end
         S_LEN: begin
            if (load_en) begin
               data_nx  = len_byte;
               valid_nx = 1'b1;
               csum_nx  = csum ^ len_byte;
               state_nx = (len_q != '0) ? S_PAY : S_CSUM;
            end
         end
         S_PAY: begin
            src_ready = gnt & {2{load_en}};
            if (sel_valid && load_en) begin
               data_nx  = enc_byte;
               valid_nx = 1'b1;
               csum_nx  = csum ^ enc_byte;
               cnt_nx   = cnt + LEN_W'(1);
               if (cnt == len_q - LEN_W'(1))
                  state_nx = S_CSUM;
            end
         end
         S_CSUM: begin
            // Load the checksum once, then wait for its handshake.
            if (tx_valid && tx_last) begin
               if (tx_ready) begin
                  gnt_nx   = 2'b00;
                  state_nx = S_IDLE;
               end
            end else if (load_en) begin
               data_nx  = csum;
               valid_nx = 1'b1;
               last_nx  = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule
